bmac_acc_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational BMAC lane-dot-product unit.
- Each accepted beat carries LANES packed unsigned lanes per operand. The block multiplies lane-wise, reduces with an adder tree, and accumulates across beats until a beat marked last.
- Sits between an operand streamer and a result FIFO. Valid/ready handshake on both sides.

---
 rtl/bmac_pkg.sv | 21 ++
 rtl/bmac_lane_tree.sv | 69 ++++++
 rtl/bmac_acc_pipe.sv | 101 ++++++++++
 tb/tb_bmac_acc_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bmac_pkg.sv
// Shared types and sizing helpers for the BMAC lane-dot-product datapath.
package bmac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } bmac_state_e;

    localparam int unsigned BMAC_LANES_DEF      = 8;
    localparam int unsigned BMAC_LANE_WIDTH_DEF = 4;
    localparam int unsigned BMAC_ACC_WIDTH_DEF  = 16;

    // Width of the full lane-product sum: one product plus log2(LANES) carry bits.
    function automatic int unsigned bmac_sum_width(input int unsigned lanes,
                                                   input int unsigned lane_width);
        return 2 * lane_width + $clog2(lanes);
    endfunction

endpackage

// File: rtl/bmac_lane_tree.sv
// Lane-wise multiply registered in S1, adder-tree reduction registered in S2.
module bmac_lane_tree
    import bmac_pkg::*;
#(
    parameter int unsigned LANES      = BMAC_LANES_DEF,
    parameter int unsigned LANE_WIDTH = BMAC_LANE_WIDTH_DEF,
    parameter int unsigned SUM_W      = bmac_sum_width(LANES, LANE_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_fire,
    input  logic [LANES*LANE_WIDTH-1:0] in_a,
    input  logic [LANES*LANE_WIDTH-1:0] in_b,
    input  logic                        in_last,
    output logic                        s2_valid,
    output logic                        s2_last,
    output logic [SUM_W-1:0]            s2_sum
);

    localparam int unsigned PW = 2 * LANE_WIDTH;

    logic [LANES-1:0][PW-1:0] prod_d, prod_q;
    logic                     s1_valid_q, s1_last_q;
    logic [SUM_W-1:0]         sum_d, sum_q;
    logic                     s2_valid_q, s2_last_q;

    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[i] = PW'(in_a[i*LANE_WIDTH +: LANE_WIDTH]) *
                        PW'(in_b[i*LANE_WIDTH +: LANE_WIDTH]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    // S1 only loads on an accepted beat; an idle input leaves a bubble behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            sum_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= in_fire;
            s1_last_q  <= in_fire & in_last;
            if (in_fire) begin
                prod_q <= prod_d;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                sum_q <= sum_d;
            end
        end
    end

    assign s2_valid = s2_valid_q;
    assign s2_last  = s2_last_q;
    assign s2_sum   = sum_q;

endmodule

// File: rtl/bmac_acc_pipe.sv
// Pipelined BMAC dot-product accumulator with valid/ready framing.
// Define BMAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module bmac_acc_pipe
    import bmac_pkg::*;
#(
    parameter int unsigned LANES      = BMAC_LANES_DEF,
    parameter int unsigned LANE_WIDTH = BMAC_LANE_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = BMAC_ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*LANE_WIDTH-1:0] in_a,
    input  logic [LANES*LANE_WIDTH-1:0] in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_data,
    output logic                        out_ovf
);

    localparam int unsigned SUM_W = bmac_sum_width(LANES, LANE_WIDTH);

    bmac_state_e          state_d, state_q;
    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                 ovf_d, ovf_q;
    logic                 ready_en_d, ready_en_q;
    logic [ACC_WIDTH:0]   add_ext;
    logic                 in_fire;
    logic                 s2_valid, s2_last;
    logic [SUM_W-1:0]     s2_sum;

    assign in_ready  = ready_en_q && (state_q == IDLE || state_q == ACCUM);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

    bmac_lane_tree #(
        .LANES      (LANES),
        .LANE_WIDTH (LANE_WIDTH),
        .SUM_W      (SUM_W)
    ) u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_fire  (in_fire),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .s2_valid (s2_valid),
        .s2_last  (s2_last),
        .s2_sum   (s2_sum)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        ready_en_d = 1'b1;
        add_ext    = {1'b0, acc_q} + (ACC_WIDTH + 1)'(s2_sum);

        unique case (state_q)
            IDLE:    if (in_fire) state_d = in_last ? DRAIN : ACCUM;
            ACCUM:   if (in_fire && in_last) state_d = DRAIN;
            DRAIN:   if (s2_valid && s2_last) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (s2_valid) begin
            ovf_d = ovf_q | add_ext[ACC_WIDTH];
`ifdef BMAC_SAT_EN
            // Once clamped, the frame stays pinned at full scale.
            acc_d = (ovf_q || add_ext[ACC_WIDTH]) ? '1 : add_ext[ACC_WIDTH-1:0];
`else
            acc_d = add_ext[ACC_WIDTH-1:0];
`endif
        end

        if (state_q == HOLD && out_ready) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            ready_en_q <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_bmac_acc_pipe.sv
// Directed self-checking bench for bmac_acc_pipe with hand-computed dot products.
module tb_bmac_acc_pipe;

    localparam int unsigned LANES      = 8;
    localparam int unsigned LANE_WIDTH = 4;
    localparam int unsigned ACC_WIDTH  = 16;

    logic                        clk;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*LANE_WIDTH-1:0] in_a;
    logic [LANES*LANE_WIDTH-1:0] in_b;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_WIDTH-1:0]        out_data;
    logic                        out_ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    bmac_acc_pipe #(
        .LANES      (LANES),
        .LANE_WIDTH (LANE_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge and return at the negedge after it is accepted.
    task automatic beat(input logic [3:0] la, input logic [3:0] lb,
                        input logic last, input logic keep);
        int unsigned n;
        n        = 0;
        in_a     = {8{la}};
        in_b     = {8{lb}};
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL beat_accept: waited=%0d cycles, required < 50", n);
        end
        @(negedge clk);
        if (!keep) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_out(input string tag);
        int unsigned n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 20) else begin
            errors++;
            $error("FAIL %s_timeout: waited=%0d cycles, required < 20", tag, n);
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
        check({tag, "_acc_clear"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        logic [15:0] ovf_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready_still_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst_ready_rise", 32'(in_ready), 32'd1);

        // Single beat: 8 * 13 * 15 = 1560.
        beat(4'hD, 4'hF, 1'b1, 1'b0);
        check("single_drain_ready", 32'(in_ready), 32'd0);
        check("single_lat_t1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_lat_t2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_lat_t3", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h0618);
        check("single_ovf", 32'(out_ovf), 32'd0);
        consume("single");

        // Two beats back-to-back: 1560 + 240 = 1800.
        beat(4'hD, 4'hF, 1'b0, 1'b1);
        check("two_ready_b2b", 32'(in_ready), 32'd1);
        beat(4'h2, 4'hF, 1'b1, 1'b0);
        wait_out("two");
        check("two_data", 32'(out_data), 32'h0708);
        check("two_ovf", 32'(out_ovf), 32'd0);
        consume("two");

        // out_ready pulsed while idle must not disturb the next frame.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready_pulse_valid", 32'(out_valid), 32'd0);

        // Backpressure: 8 * 3 * 5 = 120, held for 5 cycles.
        beat(4'h3, 4'h5, 1'b1, 1'b0);
        wait_out("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h0078);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        consume("bp");
        beat(4'h1, 4'h1, 1'b1, 1'b0);
        wait_out("bp_next");
        check("bp_next_data", 32'(out_data), 32'h0008);
        consume("bp_next");

        // Overflow: 43 * 1560 = 67080 exceeds 16 bits.
        for (int i = 0; i < 42; i++) begin
            beat(4'hD, 4'hF, 1'b0, 1'b1);
        end
        beat(4'hD, 4'hF, 1'b1, 1'b0);
        wait_out("ovf");
`ifdef BMAC_SAT_EN
        ovf_exp = 16'hFFFF;
`else
        ovf_exp = 16'h0608;
`endif
        check("ovf_data", 32'(out_data), 32'(ovf_exp));
        check("ovf_flag", 32'(out_ovf), 32'd1);
        consume("ovf");
        check("ovf_flag_clear", 32'(out_ovf), 32'd0);

        // Bubbles between beats: 3 * 1800 = 5400.
        beat(4'hF, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        beat(4'hF, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        beat(4'hF, 4'hF, 1'b1, 1'b0);
        wait_out("bub");
        check("bub_data", 32'(out_data), 32'h1518);
        check("bub_ovf", 32'(out_ovf), 32'd0);
        consume("bub");

        // Reset mid-frame discards the partial accumulation.
        beat(4'hD, 4'hF, 1'b0, 1'b1);
        beat(4'hD, 4'hF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(4'h2, 4'hF, 1'b1, 1'b0);
        wait_out("post_rst");
        check("post_rst_data", 32'(out_data), 32'h00F0);
        check("post_rst_ovf", 32'(out_ovf), 32'd0);
        consume("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
